// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// Duty scale matches the generator's 0..999 timebase.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } state_e;

  localparam int PWM_SCALE = 1000;
  localparam int DUTY_W    = 10;
  localparam int SCALE_W   = 10;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [63:0] q
  );
    logic [DUTY_W-1:0] r;
    if (q >= 64'(PWM_SCALE)) begin
      r = DUTY_W'(PWM_SCALE - 1);
    end else begin
      r = q[DUTY_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider: one quotient bit per cycle,
// start/busy/done handshake, result held until next done.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int NUM_W = 26,
  parameter int DEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quot
);

  localparam int CW = $clog2(NUM_W + 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quot_q, quot_d;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    num_d  = num_q;
    den_d  = den_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    trial  = {rem_q, num_q[NUM_W-1]};
    diff   = trial - {1'b0, den_q};
    if (busy_q) begin
      // numerator register doubles as quotient shift register
      num_d = {num_q[NUM_W-2:0], 1'b0};
      rem_d = trial[DEN_W-1:0];
      if (trial >= {1'b0, den_q}) begin
        rem_d    = diff[DEN_W-1:0];
        num_d[0] = 1'b1;
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        quot_d = num_d;
      end
    end else if (i_start) begin
      busy_d = 1'b1;
      num_d  = i_num;
      den_d  = i_den;
      rem_d  = '0;
      cnt_d  = CW'(NUM_W);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      num_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      den_q  <= den_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_quot = quot_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time capture with stuck detection.
// Define PWM_CAPTURE_DUTY_EN to build the per-mille duty divider.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pwm,
  output logic [CNT_W-1:0]  o_period,
  output logic [CNT_W-1:0]  o_high,
  output logic              o_valid,
  output logic              o_stuck,
  output logic              o_level,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_duty_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

  logic             sync1_q;
  logic             s_q;
  logic             s_dly_q;
  logic             rise;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] p_inc;
  logic [CNT_W-1:0] h_inc;

  assign rise  = s_q & ~s_dly_q;
  assign p_inc = (p_q == CNT_MAX) ? p_q : p_q + 1'b1;
  assign h_inc = (h_q == CNT_MAX) ? h_q : h_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= i_pwm;
      s_q     <= sync1_q;
      s_dly_q <= s_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    h_d      = h_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          p_d     = CNT_ONE;
          h_d     = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // a rise on the timeout cycle still reports the sample
        if (rise) begin
          period_d = p_q;
          high_d   = h_q;
          valid_d  = 1'b1;
          p_d      = CNT_ONE;
          h_d      = CNT_ONE;
        end else if (p_q >= TO_LIM) begin
          state_d = STUCK;
        end else begin
          p_d = p_inc;
          if (s_q) begin
            h_d = h_inc;
          end
        end
      end
      STUCK: begin
        if (rise) begin
          p_d     = CNT_ONE;
          h_d     = CNT_ONE;
          state_d = MEASURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      p_q      <= '0;
      h_q      <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      h_q      <= h_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_stuck  = (state_q == STUCK);
  assign o_level  = s_q;

`ifdef PWM_CAPTURE_DUTY_EN
  localparam int NUM_W = CNT_W + SCALE_W;

  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] quot;
  logic             div_busy;
  logic             div_done;

  assign num = NUM_W'(high_q) * NUM_W'(PWM_SCALE);

  // samples arriving while busy are dropped by the divider
  pwm_duty_div #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W)
  ) u_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (valid_q),
    .i_num   (num),
    .i_den   (period_q),
    .o_busy  (div_busy),
    .o_done  (div_done),
    .o_quot  (quot)
  );

  logic unused_busy;
  assign unused_busy  = div_busy;
  assign o_duty       = clamp_duty(64'(quot));
  assign o_duty_valid = div_done;
`else
  assign o_duty       = '0;
  assign o_duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveform table plus stuck, reset
// and long-period sequences against a segment-level model.
module tb_pwm_capture;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [1:0] pwm = 2'b00;

  logic [15:0] a_period, a_high, b_period, b_high;
  logic        a_valid, a_stuck, a_level, a_dv;
  logic        b_valid, b_stuck, b_level, b_dv;
  logic [9:0]  a_duty, b_duty;

  always #5 i_clk = ~i_clk;

  pwm_capture dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pwm        (pwm[0]),
    .o_period     (a_period),
    .o_high       (a_high),
    .o_valid      (a_valid),
    .o_stuck      (a_stuck),
    .o_level      (a_level),
    .o_duty       (a_duty),
    .o_duty_valid (a_dv)
  );

  pwm_capture #(.TIMEOUT(100)) dut_t (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pwm        (pwm[1]),
    .o_period     (b_period),
    .o_high       (b_high),
    .o_valid      (b_valid),
    .o_stuck      (b_stuck),
    .o_level      (b_level),
    .o_duty       (b_duty),
    .o_duty_valid (b_dv)
  );

  localparam int DUTY_LAT = 16 + 11;

  typedef struct {
    int cyc;
    int per;
    int hi;
  } samp_t;

  typedef struct {
    int cyc;
    int duty;
  } duty_t;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_per;
    int exp_hi;
    int exp_duty;
  } vec_t;

  samp_t vq[$];
  samp_t bvq[$];
  duty_t dq[$];
  int    astk[$];
  int    bstk[$];
  int    cyc = 0;
  logic  a_stuck_p = 1'b0;
  logic  b_stuck_p = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  vec_t  tbl[12];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (a_valid === 1'b1) vq.push_back('{cyc, int'(a_period), int'(a_high)});
    if (b_valid === 1'b1) bvq.push_back('{cyc, int'(b_period), int'(b_high)});
    if (a_dv === 1'b1) dq.push_back('{cyc, int'(a_duty)});
    if (a_stuck === 1'b1 && a_stuck_p !== 1'b1) astk.push_back(cyc);
    if (b_stuck === 1'b1 && b_stuck_p !== 1'b1) bstk.push_back(cyc);
    a_stuck_p = a_stuck;
    b_stuck_p = b_stuck;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int duty_of(input int h, input int p);
    int d;
    d = (h * 1000) / p;
    return (d > 999) ? 999 : d;
  endfunction

  task automatic seg(input int ch, input logic lvl, input int n);
    pwm[ch] = lvl;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    chk("rst_period", 32'(a_period), 0);
    chk("rst_high", 32'(a_high), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_stuck", 32'(a_stuck), 0);
    chk("rst_level", 32'(a_level), 0);
    chk("rst_duty", 32'(a_duty), 0);
    chk("rst_dvalid", 32'(a_dv), 0);
    chk("rst_b_stuck", 32'(b_stuck), 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    int v0, v2, last;
    int ecyc[$];
    int eduty[$];

    tbl[0] = '{300, 700, 3, 0, 0, 0};
    tbl[1] = '{3, 4, 9, 0, 0, 0};
    tbl[2] = '{1, 1, 6, 0, 0, 0};
    tbl[3] = '{1, 98, 4, 0, 0, 0};
    tbl[4] = '{98, 1, 4, 0, 0, 0};
    tbl[5] = '{10, 90, 3, 0, 0, 0};
    for (int e = 6; e < 12; e++) begin
      tbl[e].hi = int'($urandom_range(1, 80));
      tbl[e].lo = int'($urandom_range(1, 80));
      tbl[e].n  = 5;
    end
    for (int e = 0; e < 12; e++) begin
      tbl[e].exp_per  = tbl[e].hi + tbl[e].lo;
      tbl[e].exp_hi   = tbl[e].hi;
      tbl[e].exp_duty = duty_of(tbl[e].hi, tbl[e].exp_per);
    end

    #2;
    for (int e = 0; e < 12; e++) begin
      do_reset();
      vq.delete();
      dq.delete();
      seg(0, 1'b0, 5);
      for (int k = 0; k < tbl[e].n; k++) begin
        seg(0, 1'b1, tbl[e].hi);
        seg(0, 1'b0, tbl[e].lo);
      end
      seg(0, 1'b1, tbl[e].hi);
      seg(0, 1'b0, 40);
      chk($sformatf("v%0d_count", e), vq.size(), tbl[e].n);
      if (vq.size() > 0) begin
        v0 = vq[0].cyc;
        for (int i = 0; i < vq.size() && i < tbl[e].n; i++) begin
          chk($sformatf("v%0d_s%0d_period", e, i), vq[i].per, tbl[e].exp_per);
          chk($sformatf("v%0d_s%0d_high", e, i), vq[i].hi, tbl[e].exp_hi);
          chk($sformatf("v%0d_s%0d_time", e, i), vq[i].cyc - v0,
              i * tbl[e].exp_per);
        end
`ifdef PWM_CAPTURE_DUTY_EN
        ecyc.delete();
        eduty.delete();
        last = v0 - 1000;
        for (int i = 0; i < tbl[e].n; i++) begin
          if (v0 + i * tbl[e].exp_per >= last + DUTY_LAT) begin
            last = v0 + i * tbl[e].exp_per;
            ecyc.push_back(last + DUTY_LAT);
            eduty.push_back(tbl[e].exp_duty);
          end
        end
        chk($sformatf("v%0d_duty_count", e), dq.size(), ecyc.size());
        for (int i = 0; i < dq.size() && i < ecyc.size(); i++) begin
          chk($sformatf("v%0d_d%0d_time", e, i), dq[i].cyc, ecyc[i]);
          chk($sformatf("v%0d_d%0d_duty", e, i), dq[i].duty, eduty[i]);
        end
`else
        chk($sformatf("v%0d_no_duty", e), dq.size(), 0);
        chk($sformatf("v%0d_duty_zero", e), 32'(a_duty), 0);
`endif
      end
    end

    // stuck handling on the TIMEOUT=100 instance
    do_reset();
    bvq.delete();
    bstk.delete();
    seg(1, 1'b0, 5);
    seg(1, 1'b1, 10);
    seg(1, 1'b0, 20);
    seg(1, 1'b1, 10);
    seg(1, 1'b0, 90);
    seg(1, 1'b1, 10);
    seg(1, 1'b0, 91);
    seg(1, 1'b1, 10);
    seg(1, 1'b0, 300);
    chk("to_valid_count", bvq.size(), 2);
    chk("to_stuck_low", 32'(b_stuck), 1);
    chk("to_level_low", 32'(b_level), 0);
    chk("to_stuck_events", bstk.size(), 2);
    if (bvq.size() == 2 && bstk.size() == 2) begin
      chk("to_s0_period", bvq[0].per, 30);
      chk("to_s0_high", bvq[0].hi, 10);
      chk("to_edge_period", bvq[1].per, 100);
      chk("to_edge_high", bvq[1].hi, 10);
      v2 = bvq[1].cyc;
      chk("to_p101_stuck_time", bstk[0], v2 + 100);
      chk("to_low_stuck_time", bstk[1], v2 + 201);
    end
    seg(1, 1'b1, 5);
    chk("to_stuck_cleared", 32'(b_stuck), 0);
    seg(1, 1'b1, 155);
    chk("to_stuck_high", 32'(b_stuck), 1);
    chk("to_level_high", 32'(b_level), 1);
    chk("to_no_valid_after", bvq.size(), 2);
    chk("to_stuck_events3", bstk.size(), 3);
    seg(1, 1'b0, 5);

    // reset in the middle of a 500/1000 period
    do_reset();
    vq.delete();
    seg(0, 1'b0, 5);
    seg(0, 1'b1, 500);
    seg(0, 1'b0, 500);
    seg(0, 1'b1, 500);
    seg(0, 1'b0, 250);
    chk("mid_pre_period", 32'(a_period), 1000);
    do_reset();
    vq.delete();
    dq.delete();
    seg(0, 1'b0, 250);
    seg(0, 1'b1, 500);
    seg(0, 1'b0, 500);
    chk("mid_one_rise", vq.size(), 0);
    seg(0, 1'b1, 500);
    seg(0, 1'b0, 40);
    chk("mid_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("mid_period", vq[0].per, 1000);
      chk("mid_high", vq[0].hi, 500);
    end
`ifdef PWM_CAPTURE_DUTY_EN
    chk("mid_duty_count", dq.size(), 1);
    if (dq.size() > 0) chk("mid_duty", dq[0].duty, 500);
`endif

    // period longer than the counter range
    do_reset();
    vq.delete();
    astk.delete();
    seg(0, 1'b0, 5);
    seg(0, 1'b1, 100);
    seg(0, 1'b0, 65536);
    chk("long_stuck", 32'(a_stuck), 1);
    chk("long_level", 32'(a_level), 0);
    chk("long_no_valid", vq.size(), 0);
    seg(0, 1'b1, 10);
    chk("long_cleared", 32'(a_stuck), 0);
    chk("long_no_valid2", vq.size(), 0);
    seg(0, 1'b0, 10);
    seg(0, 1'b1, 10);
    seg(0, 1'b0, 40);
    chk("long_stuck_events", astk.size(), 1);
    chk("long_count", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("long_period", vq[0].per, 20);
      chk("long_high", vq[0].hi, 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the light PWM generator. Samples an external PWM waveform and measures its period and high time in i_clk cycles, and optionally its duty in per-mille (0..999, the same scale as the generator's 0..999 timebase). Used for loop-back checking of the PWM light output and for reading external PWM sensors. Reports a stuck output when no rising edge arrives in time.

## Interface
- CNT_W, 16: width of period/high counters and outputs.
- TIMEOUT, 65535: cycles without a rising edge before the stuck condition; must be ≤ 2^CNT_W−1.
- i_clk  input  1  clock.
- i_reset  input  1  reset, asynchronous, active-high.
- i_pwm  input  1  asynchronous PWM input.
- o_period  output  CNT_W  last measured period, in cycles.
- o_high  output  CNT_W  last measured high time, in cycles.
- o_valid  output  1  one-cycle strobe: o_period/o_high updated.
- o_stuck  output  1  no rising edge within TIMEOUT cycles.
- o_level  output  1  synchronized input level; meaningful while o_stuck=1.
- o_duty  output  10  per-mille duty (PWM_CAPTURE_DUTY_EN only).
- o_duty_valid  output  1  one-cycle strobe for o_duty (PWM_CAPTURE_DUTY_EN only).

## Operation
- Input path: 2-flop synchronizer, then one delay flop for edge detect. rise = s & ~s_d, fall = ~s & s_d.
- FSM states: IDLE, MEASURE, STUCK.
- IDLE (after reset): wait for rise. On rise: p←1, h←1, go to MEASURE. Outputs not updated.
- MEASURE: each cycle p increments. h increments while s=1 and no fall has occurred since the last rise; h freezes at fall.
  - On rise: o_period←p, o_high←h, o_valid=1 next cycle; then p←1, h←1.
  - If p reaches TIMEOUT with no rise: go to STUCK.
- STUCK: o_stuck=1, o_level=s. On rise: o_stuck←0, p←1, h←1, go to MEASURE. No o_valid for the incomplete period.
- Counters saturate at 2^CNT_W−1 and never wrap.
- o_high < o_period always holds for any sample that reports valid.
- A rise and a timeout in the same cycle: the rise wins and the sample reports normally.

## Timing
- Reset values: o_period=0, o_high=0, o_valid=0, o_stuck=0, o_level=0, o_duty=0, o_duty_valid=0; FSM in IDLE; synchronizer flops at 0.
- Input-to-detect latency: 3 cycles from an i_pwm transition to rise/fall.
- o_valid asserts in the cycle after the detected rise. o_period/o_high hold their values until the next o_valid.
- o_stuck asserts in the cycle after p reaches TIMEOUT, and clears in the cycle after the next rise.
- Asynchronous reset mid-measurement aborts the measurement and any division in progress. The first o_valid after reset needs two rising edges.

## Configuration
- PWM_CAPTURE_DUTY_EN defined:
  - On each o_valid, if the divider is idle, it computes o_duty = (o_high×1000)/o_period (floor), clamped to 999.
  - The result is a serial restoring divide, one quotient bit per cycle, with numerator width CNT_W+10.
  - o_duty_valid pulses CNT_W+11 cycles after o_valid.
  - If the divider is busy when o_valid fires, that sample is skipped for duty; o_period/o_high still update.
- PWM_CAPTURE_DUTY_EN undefined: no divider logic is built. o_duty is tied to 0 and o_duty_valid to 0.

## Structure
- Shared package pwm_pkg:
  - FSM state typedef {IDLE, MEASURE, STUCK}.
  - Constant PWM_SCALE=1000.
  - Constant DUTY_W=10.
- Sub-module pwm_duty_div: start/busy/done serial divider with parameterized width. Instantiated only under PWM_CAPTURE_DUTY_EN.

## Test plan
- Steady PWM, 300 high / 1000 period cycles → from the second rise on, o_valid each period with o_period=1000, o_high=300; o_duty=300 with DUTY_EN.
- Period 7, high 3 (TIMEOUT default) → o_period=7, o_high=3. Divider busy on most samples, so only every 4th sample gives o_duty=428.
- i_pwm held low after two rises, TIMEOUT=100 → o_stuck=1, o_level=0 about 100 cycles after the last rise; next rise clears o_stuck with no o_valid.
- i_pwm held high, TIMEOUT=100 → o_stuck=1, o_level=1.
- i_reset pulsed mid-period of a 500/1000 waveform → all outputs 0 immediately, FSM in IDLE; first o_valid only after two subsequent rises, with correct values.
- Period 2^CNT_W+100 with TIMEOUT=65535 → o_stuck asserts, counters never wrap, no o_valid carrying a wrapped value.
